scan_select_sequencer: RTL
==========================

// Module: scan_select_sequencer
// PURPOSE
//   Sequencer that drives the 3-bit select of the 3-to-8 one-hot decoder stage.
//   Steps through the enabled channels of an 8-bit mask in ascending order.
//   Holds each channel for a programmable dwell time.
//   Runs one frame (single-shot) or repeats frames (continuous).
//   Downstream must qualify the decoded one-hot output with sel_valid.
// PARAMETERS
//   DWELL_W   8   width of dwell-time input and internal dwell counter
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        request to begin scan; sampled only in IDLE
//   stop         in   1        abort scan; priority over start
//   continuous   in   1        1 = wrap and repeat frames, 0 = single frame; latched at start
//   chan_mask    in   8        bit i = 1 enables channel i; latched at start
//   dwell        in   DWELL_W  cycles per channel, 0 treated as 1; latched at start
//   sel          out  3        channel index to decoder
//   sel_valid    out  1        sel is an active selection
//   busy         out  1        scan in progress
//   frame_done   out  1        one-cycle pulse after last enabled channel of a frame
//   start_err    out  1        one-cycle pulse: start seen with chan_mask == 0
// BEHAVIOUR
//   Reset (async, immediate): sel=0, sel_valid=0, busy=0, frame_done=0, start_err=0, state IDLE.
//   All outputs are registered.
//   IDLE
//     start=1 & stop=0 & mask!=0: latch mask/dwell/continuous, go to SCAN.
//       Next cycle: sel = lowest enabled channel, sel_valid=1, busy=1 (latency 1).
//     start=1 & mask==0: start_err=1 next cycle, stay IDLE.
//     start=1 & stop=1: stay IDLE, no pulse.
//   SCAN
//     sel held for exactly max(dwell,1) cycles via down-counter.
//     On the final dwell cycle, next = lowest enabled index strictly greater than sel:
//       Found: sel=next next cycle; sel_valid stays 1 with no gap.
//       None, continuous=1: sel=lowest enabled, frame_done=1 for that cycle, remain SCAN.
//       None, continuous=0: frame_done=1, sel_valid=0, busy=0, sel=0, go IDLE.
//     stop=1 in any SCAN cycle: next cycle IDLE, sel=0, sel_valid=0, busy=0, no frame_done.
//       Applies even on the final dwell cycle.
//     start ignored while busy.
//     Changes to chan_mask/dwell/continuous while busy have no effect.
//   Boundary cases
//     Single enabled channel, continuous: sel constant; frame_done every max(dwell,1) cycles.
//     Counter never wraps: loaded with max(dwell,1)-1 and decremented to 0.
//     Mid-operation reset: async return to reset values, no pulses.
// STRUCTURE
//   Package scan_pkg:
//     NUM_CH=8, SEL_W=3
//     typedef enum logic {S_IDLE, S_SCAN} scan_state_t
//   Sub-module next_chan_finder (combinational).
//     Inputs: mask[7:0], cur[2:0].
//     Outputs: found, next[2:0] (lowest set bit above cur), first[2:0] (lowest set bit).
//   Top: state register, dwell counter, latched config, output registers.
// TESTING
//   1. mask=FF, dwell=2, continuous=0, start pulse at cycle 0:
//        sel=0,0,1,1..7,7 in cycles 1-16; cycle 17 frame_done=1, sel_valid=0, busy=0.
//   2. mask=A4, dwell=1, continuous=1:
//        sel=2,5,7,2,5,7..; frame_done=1 exactly in each cycle sel returns to 2; sel_valid never drops.
//   3. dwell=0, mask=03, single-shot:
//        sel=0 then 1, one cycle each, then frame_done; identical to dwell=1.
//   4. stop during sel=3 (mask=FF, dwell=4):
//        next cycle sel=0, sel_valid=0, busy=0, no frame_done.
//      start+stop together in IDLE: no activity.
//   5. start with mask=00: start_err single pulse, busy stays 0.
//      Mask changed to 00 mid-scan: scan completes with original mask.
//   6. rst_n low mid-dwell (async, between edges): all outputs 0 immediately.
//      Release, then start: scan restarts from lowest channel.

Source files
------------

// File: rtl/scan_select_sequencer_pkg.sv
// Shared constants and state encoding for the scan select sequencer.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

endpackage

// File: rtl/scan_select_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
interface scan_select_sequencer_if #(
    parameter int DWELL_W = 8
);
    import scan_pkg::*;

    logic               start;
    logic               stop;
    logic               continuous;
    logic [NUM_CH-1:0]  chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               busy;
    logic               frame_done;
    logic               start_err;

    modport master (
        output start, stop, continuous, chan_mask, dwell,
        input  sel, sel_valid, busy, frame_done, start_err
    );

    modport slave (
        input  start, stop, continuous, chan_mask, dwell,
        output sel, sel_valid, busy, frame_done, start_err
    );

endinterface

// File: rtl/scan_select_sequencer_finder.sv
// Combinational search for the first and the next enabled channel in a mask.
module next_chan_finder
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic              found,
    output logic [SEL_W-1:0]  next,
    output logic [SEL_W-1:0]  first
);

    // Descending walk so the lowest matching index is written last.
    always_comb begin
        found = 1'b0;
        next  = '0;
        first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
                if (SEL_W'(i) > cur) begin
                    found = 1'b1;
                    next  = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/scan_select_sequencer.sv
// Steps the decoder select through enabled channels, holding each for a dwell time.
module scan_select_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scan_select_sequencer_if.slave  bus
);

    scan_state_t        r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [DWELL_W-1:0] r_dwell_ld;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_cont;
    logic [SEL_W-1:0]   r_sel;
    logic               r_valid;
    logic               r_busy;
    logic               r_fd;
    logic               r_err;

    logic [NUM_CH-1:0]  w_mask;
    logic [DWELL_W-1:0] w_dwell_ld;
    logic               w_found;
    logic [SEL_W-1:0]   w_next;
    logic [SEL_W-1:0]   w_first;

    // In IDLE the finder looks at the live mask to pick the start channel.
    assign w_mask     = (r_state == S_IDLE) ? bus.chan_mask : r_mask;
    assign w_dwell_ld = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

    next_chan_finder u_finder (
        .mask  (w_mask),
        .cur   (r_sel),
        .found (w_found),
        .next  (w_next),
        .first (w_first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_dwell_ld <= '0;
            r_cnt      <= '0;
            r_cont     <= 1'b0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_fd       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_fd  <= 1'b0;
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.chan_mask != '0) begin
                            r_mask     <= bus.chan_mask;
                            r_dwell_ld <= w_dwell_ld;
                            r_cnt      <= w_dwell_ld;
                            r_cont     <= bus.continuous;
                            r_sel      <= w_first;
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_SCAN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (bus.stop) begin
                        r_sel   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_found) begin
                        r_sel <= w_next;
                        r_cnt <= r_dwell_ld;
                    end else if (r_cont) begin
                        r_sel <= w_first;
                        r_cnt <= r_dwell_ld;
                        r_fd  <= 1'b1;
                    end else begin
                        r_fd    <= 1'b1;
                        r_sel   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.sel_valid  = r_valid;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_fd;
    assign bus.start_err  = r_err;

endmodule
